// File: rtl/sram_cluster_pkg.sv
// sram_cluster_pkg: shared encodings for the SRAM cluster request sequencer.
// Holds the req_size codes, the sequencer FSM state type and the bank lane indices.
// No ports; imported by the interface consumers, the lane decoder and the top.
package sram_cluster_pkg;

  // req_size encodings; 2'b11 is treated as a word everywhere
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bank lane indices into the 4-bit lane vectors (bit i = bank i)
  localparam int LANE_A = 0;
  localparam int LANE_B = 1;
  localparam int LANE_C = 2;
  localparam int LANE_D = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_cluster_input_if.sv
// sram_cluster_input_if: fabric request/response bundle for sram_cluster_input.
// Ports: req_valid/req_ready handshake, req_we/req_size/req_addr/req_wdata payload,
//        rsp_valid completion pulse and, with SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN, rsp_err.
interface sram_cluster_input_if #(
  parameter int ADDR_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
  logic              rsp_err;

  // Fabric side
  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err
  );
`else
  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid
  );
`endif

endinterface

// File: rtl/sram_lane_decode.sv
// sram_lane_decode: purely combinational size + byte-offset to bank lane enables.
// Ports: size_i (req_size code), lo_i (addr[1:0]) -> lane_en_o (bit i = bank i),
//        misalign_o (half on odd byte, word not on a 4-byte boundary).
module sram_lane_decode
  import sram_cluster_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] lo_i,
  output logic [3:0] lane_en_o,
  output logic       misalign_o
);

  always_comb begin
    lane_en_o  = 4'b1111;
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        lane_en_o = 4'b0001 << lo_i;
      end
      SZ_HALF: begin
        // Only bit 1 picks the pair; bit 0 is the misalignment indicator
        lane_en_o  = lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = lo_i[0];
      end
      default: begin
        // SZ_WORD and the reserved 2'b11 code both cover all four banks
        lane_en_o  = 4'b1111;
        misalign_o = |lo_i;
      end
    endcase
  end

endmodule

// File: rtl/sram_cluster_input.sv
// sram_cluster_input: fabric-to-SRAM request sequencer for a four-bank (A..D, 8-bit) cluster.
// Ports: clk, rst_n (async active-low); bus (slave modport: request handshake, rsp_valid,
//        rsp_err); csb_n_A..D, web_n, sram_addr, din_A..D to the banks; sel_out_A..D to the read mux.
// Optional SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN: misaligned requests skip the banks and return rsp_err.
module sram_cluster_input
  import sram_cluster_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_cluster_input_if.slave bus,
  output logic              csb_n_A,
  output logic              csb_n_B,
  output logic              csb_n_C,
  output logic              csb_n_D,
  output logic              web_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        din_A,
  output logic [7:0]        din_B,
  output logic [7:0]        din_C,
  output logic [7:0]        din_D,
  output logic              sel_out_A,
  output logic              sel_out_B,
  output logic              sel_out_C,
  output logic              sel_out_D
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic [3:0]        csb_q, csb_d;
  logic              web_q, web_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0][7:0]   din_q, din_d;
  logic [3:0]        sel_q, sel_d;
  logic              rsp_valid_q, rsp_valid_d;
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
  logic              rsp_err_q, rsp_err_d;
`endif

  // One decoder serves both phases: in IDLE it looks at the live request to
  // build the bank controls registered at accept; afterwards it looks at the
  // latched copy to build the read-mux flags registered on entry to DONE.
  logic       in_idle;
  logic [1:0] dec_size;
  logic [1:0] dec_lo;
  logic [3:0] lane_en;
  logic [3:0] eff_en;

  assign in_idle  = (state_q == ST_IDLE);
  assign dec_size = in_idle ? bus.req_size     : size_q;
  assign dec_lo   = in_idle ? bus.req_addr[1:0] : lo_q;

`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
  logic misalign;

  sram_lane_decode u_lane_decode (
    .size_i     (dec_size),
    .lo_i       (dec_lo),
    .lane_en_o  (lane_en),
    .misalign_o (misalign)
  );

  // A misaligned access walks the FSM but never touches a bank
  assign eff_en = misalign ? 4'b0000 : lane_en;
`else
  sram_lane_decode u_lane_decode (
    .size_i     (dec_size),
    .lo_i       (dec_lo),
    .lane_en_o  (lane_en),
    .misalign_o ()
  );

  assign eff_en = lane_en;
`endif

  // Write data steered per lane before masking. Index 0 is bank A, which
  // always carries the most significant byte of the access.
  logic [3:0][7:0] lane_dat;

  always_comb begin
    lane_dat = '0;
    case (bus.req_size)
      SZ_BYTE: lane_dat = {4{bus.req_wdata[7:0]}};
      SZ_HALF: lane_dat = {2{bus.req_wdata[7:0], bus.req_wdata[15:8]}};
      default: lane_dat = {bus.req_wdata[7:0],   bus.req_wdata[15:8],
                           bus.req_wdata[23:16], bus.req_wdata[31:24]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    lo_d        = lo_q;
    csb_d       = 4'b1111;
    web_d       = 1'b1;
    addr_d      = '0;
    din_d       = '0;
    sel_d       = 4'b0000;
    rsp_valid_d = 1'b0;
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = ST_ISSUE;
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          lo_d    = bus.req_addr[1:0];
          // Bank controls are registered here so they are valid throughout ISSUE
          csb_d   = ~eff_en;
          web_d   = ~bus.req_we;
          addr_d  = bus.req_addr[ADDR_W+1:2];
          for (int i = 0; i < 4; i++) begin
            din_d[i] = eff_en[i] ? lane_dat[i] : 8'h00;
          end
        end
      end
      ST_ISSUE: begin
        state_d     = ST_DONE;
        rsp_valid_d = 1'b1;
        sel_d       = we_q ? 4'b0000 : eff_en;
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
        rsp_err_d   = misalign;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      lo_q        <= 2'b00;
      csb_q       <= 4'b1111;
      web_q       <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      sel_q       <= 4'b0000;
      rsp_valid_q <= 1'b0;
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      csb_q       <= csb_d;
      web_q       <= web_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // req_ready is a straight decode of the state register
  assign bus.req_ready = in_idle;
  assign bus.rsp_valid = rsp_valid_q;
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
  assign bus.rsp_err   = rsp_err_q;
`endif

  assign csb_n_A   = csb_q[LANE_A];
  assign csb_n_B   = csb_q[LANE_B];
  assign csb_n_C   = csb_q[LANE_C];
  assign csb_n_D   = csb_q[LANE_D];
  assign web_n     = web_q;
  assign sram_addr = addr_q;
  assign din_A     = din_q[LANE_A];
  assign din_B     = din_q[LANE_B];
  assign din_C     = din_q[LANE_C];
  assign din_D     = din_q[LANE_D];
  assign sel_out_A = sel_q[LANE_A];
  assign sel_out_B = sel_q[LANE_B];
  assign sel_out_C = sel_q[LANE_C];
  assign sel_out_D = sel_q[LANE_D];

endmodule

// File: tb/tb_sram_cluster_input.sv
// tb_sram_cluster_input: directed plus random requests checked against a byte-span model.
// Ports: none; drives sram_cluster_input through an sram_cluster_input_if instance.
// Honours SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN for the misaligned-access expectations.
module tb_sram_cluster_input;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       csb_n_A, csb_n_B, csb_n_C, csb_n_D;
  logic       web_n;
  logic [7:0] sram_addr;
  logic [7:0] din_A, din_B, din_C, din_D;
  logic       sel_out_A, sel_out_B, sel_out_C, sel_out_D;

  int checks = 0;
  int errors = 0;

  // Observations from the most recent run_req, for spot checks against literals
  logic [3:0]  obs_csb;
  logic [31:0] obs_din;
  logic [7:0]  obs_addr;
  logic        obs_web;
  logic [3:0]  obs_sel;

  sram_cluster_input_if #(.ADDR_W(8)) bus ();

  sram_cluster_input #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .csb_n_A   (csb_n_A),
    .csb_n_B   (csb_n_B),
    .csb_n_C   (csb_n_C),
    .csb_n_D   (csb_n_D),
    .web_n     (web_n),
    .sram_addr (sram_addr),
    .din_A     (din_A),
    .din_B     (din_B),
    .din_C     (din_C),
    .din_D     (din_D),
    .sel_out_A (sel_out_A),
    .sel_out_B (sel_out_B),
    .sel_out_C (sel_out_C),
    .sel_out_D (sel_out_D)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cur_csb();
    return {csb_n_D, csb_n_C, csb_n_B, csb_n_A};
  endfunction

  function automatic logic [3:0] cur_sel();
    return {sel_out_D, sel_out_C, sel_out_B, sel_out_A};
  endfunction

  // Full request: wait for ready, handshake, then check ISSUE, DONE and the
  // return to IDLE. Expectations come from the byte span the access covers:
  // n bytes starting at the offset rounded down to n, bank A holding the most
  // significant byte of the span.
  task automatic run_req(input logic we, input logic [1:0] sz,
                         input logic [9:0] addr, input logic [31:0] wd);
    int         n;
    int         lo;
    int         base;
    int         t;
    logic       mis;
    logic [3:0] en;
    logic [7:0] dexp [4];
    logic [7:0] dob  [4];
    logic [31:0] tmp;

    n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lo   = int'(addr) % 4;
    base = lo - (lo % n);
    mis  = (lo % n) != 0;
    en   = 4'b0000;
    for (int i = 0; i < 4; i++) dexp[i] = 8'h00;
    for (int i = 0; i < n; i++) begin
      en[base + i]   = 1'b1;
      tmp            = wd >> (8 * (n - 1 - i));
      dexp[base + i] = tmp[7:0];
    end
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
    if (mis) en = 4'b0000;
`else
    mis = 1'b0;
`endif

    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", {31'd0, bus.req_ready}, 32'd1);

    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;

    // ISSUE
    @(negedge clk);
    obs_csb  = cur_csb();
    obs_web  = web_n;
    obs_addr = sram_addr;
    obs_din  = {din_A, din_B, din_C, din_D};
    dob[0] = din_A; dob[1] = din_B; dob[2] = din_C; dob[3] = din_D;
    chk("issue_csb",  {28'd0, obs_csb}, {28'd0, ~en});
    chk("issue_addr", {24'd0, obs_addr}, {24'd0, addr[9:2]});
    chk("issue_rsp",  {31'd0, bus.rsp_valid}, 32'd0);
    chk("issue_rdy",  {31'd0, bus.req_ready}, 32'd0);
    if (!mis) begin
      chk("issue_web", {31'd0, obs_web}, {31'd0, ~we});
      for (int i = 0; i < 4; i++)
        chk($sformatf("issue_din%0d", i), {24'd0, dob[i]}, {24'd0, dexp[i]});
    end

    // DONE
    @(negedge clk);
    obs_sel = cur_sel();
    chk("done_rsp", {31'd0, bus.rsp_valid}, 32'd1);
    chk("done_sel", {28'd0, obs_sel}, {28'd0, (we ? 4'b0000 : en)});
    chk("done_csb", {28'd0, cur_csb()}, 32'hF);
    chk("done_rdy", {31'd0, bus.req_ready}, 32'd0);
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
    chk("done_err", {31'd0, bus.rsp_err}, {31'd0, mis});
`endif

    // Back in IDLE
    @(negedge clk);
    chk("idle_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    chk("idle_rdy", {31'd0, bus.req_ready}, 32'd1);
    chk("idle_sel", {28'd0, cur_sel()}, 32'd0);
  endtask

  initial begin
    logic       exp_rdy [5];
    logic       exp_rsp [5];
    int         pulses;
    logic       rw;
    logic [1:0] rsz;
    logic [9:0] ra;
    logic [31:0] rd;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values
    #12;
    chk("rst_csb",  {28'd0, cur_csb()}, 32'hF);
    chk("rst_web",  {31'd0, web_n}, 32'd1);
    chk("rst_addr", {24'd0, sram_addr}, 32'd0);
    chk("rst_din",  {din_A, din_B, din_C, din_D}, 32'd0);
    chk("rst_sel",  {28'd0, cur_sel()}, 32'd0);
    chk("rst_rsp",  {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rdy",  {31'd0, bus.req_ready}, 32'd1);
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
    chk("rst_err",  {31'd0, bus.rsp_err}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Word write
    run_req(1'b1, 2'b10, 10'h010, 32'hDEADBEEF);
    chk("ww_din",  obs_din, 32'hDEADBEEF);
    chk("ww_csb",  {28'd0, obs_csb}, 32'h0);
    chk("ww_web",  {31'd0, obs_web}, 32'd0);
    chk("ww_addr", {24'd0, obs_addr}, 32'h04);

    // Byte read of bank C
    run_req(1'b0, 2'b00, 10'h00E, 32'h0);
    chk("br_csb",  {28'd0, obs_csb}, 32'hB);
    chk("br_web",  {31'd0, obs_web}, 32'd1);
    chk("br_addr", {24'd0, obs_addr}, 32'h03);
    chk("br_sel",  {28'd0, obs_sel}, 32'h4);

    // Half write to the C/D pair
    run_req(1'b1, 2'b01, 10'h006, 32'h00001234);
    chk("hw_csb", {28'd0, obs_csb}, 32'h3);
    chk("hw_din", obs_din, 32'h00001234);

    // Misaligned word read
    run_req(1'b0, 2'b10, 10'h001, 32'h0);
`ifdef SRAM_CLUSTER_INPUT_ALIGN_CHECK_EN
    chk("mis_csb", {28'd0, obs_csb}, 32'hF);
    chk("mis_sel", {28'd0, obs_sel}, 32'h0);
`else
    chk("mis_csb",  {28'd0, obs_csb}, 32'h0);
    chk("mis_addr", {24'd0, obs_addr}, 32'h00);
    chk("mis_sel",  {28'd0, obs_sel}, 32'hF);
`endif

    // Back-to-back reads with req_valid held high
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 10'h020;
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_rsp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pulses  = 0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_rdy%0d", i), {31'd0, bus.req_ready}, {31'd0, exp_rdy[i]});
      chk($sformatf("b2b_rsp%0d", i), {31'd0, bus.rsp_valid}, {31'd0, exp_rsp[i]});
      if (bus.rsp_valid) pulses++;
      if (i == 4) bus.req_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_rdy_end", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_rsp_end", {31'd0, bus.rsp_valid}, 32'd0);
    chk("b2b_pulses", pulses, 32'd2);

    // Reset during ISSUE of a word write
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 10'h044;
    bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mr_issue_csb", {28'd0, cur_csb()}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mr_csb",  {28'd0, cur_csb()}, 32'hF);
    chk("mr_web",  {31'd0, web_n}, 32'd1);
    chk("mr_din",  {din_A, din_B, din_C, din_D}, 32'd0);
    chk("mr_addr", {24'd0, sram_addr}, 32'd0);
    chk("mr_rdy",  {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mr_norsp%0d", i), {31'd0, bus.rsp_valid}, 32'd0);
      chk($sformatf("mr_rdy%0d", i), {31'd0, bus.req_ready}, 32'd1);
    end

    // Random requests
    for (int k = 0; k < 40; k++) begin
      rw  = 1'($urandom % 2);
      rsz = 2'($urandom % 4);
      ra  = 10'($urandom % 1024);
      rd  = $urandom;
      run_req(rw, rsz, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
